// File: rtl/pea_pkg.sv
// PE array shared types and constants.
// Used by the accumulator and the PE config registers.
package pea_pkg;

  localparam int N_BITS    = 32;
  localparam int ACC_CNT_W = 8;

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } acc_state_t;

endpackage

// File: rtl/pe_accumulator.sv
// Windowed accumulator behind the PE functional unit.
// Sums acc_len valid samples, emits one registered sum per window.
module pe_accumulator
  import pea_pkg::*;
#(
  parameter int N_BITS = pea_pkg::N_BITS,
  parameter int CNT_W  = ACC_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  acc_len_i,
  input  logic [N_BITS-1:0] data_i,
  input  logic              valid_i,
  output logic [N_BITS-1:0] acc_o,
  output logic              acc_valid_o,
  output logic              ovf_o,
  output logic              busy_o
);

  acc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [N_BITS-1:0] sum_q, sum_d;
  logic              ovf_win_q, ovf_win_d;

  logic [N_BITS-1:0] acc_q;
  logic              acc_valid_q;
  logic              ovf_q;

  logic [N_BITS-1:0] sum_add;
  logic              add_ovf;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              emit;
  logic [N_BITS-1:0] emit_sum;
  logic              emit_ovf;

  // Next-sum, overflow detect and window FSM next state.
  always_comb begin
    sum_add   = sum_q + data_i;
    add_ovf   = (sum_q[N_BITS-1] == data_i[N_BITS-1]) &&
                (sum_add[N_BITS-1] != sum_q[N_BITS-1]);
    cnt_inc   = count_q + CNT_W'(1);
    accept    = en_i & valid_i & ~clear_i;
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    sum_d     = sum_q;
    ovf_win_d = ovf_win_q;
    emit      = 1'b0;
    emit_sum  = sum_add;
    emit_ovf  = ovf_win_q | add_ovf;
    if (clear_i) begin
      state_d   = ACC_IDLE;
      count_d   = '0;
      sum_d     = '0;
      ovf_win_d = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        ACC_IDLE: begin
          len_d     = acc_len_i;
          sum_d     = data_i;
          ovf_win_d = 1'b0;
          if (acc_len_i <= CNT_W'(1)) begin
            emit     = 1'b1;
            emit_sum = data_i;
            emit_ovf = 1'b0;
            count_d  = '0;
          end else begin
            count_d = CNT_W'(1);
            state_d = ACC_RUN;
          end
        end
        ACC_RUN: begin
          sum_d     = sum_add;
          count_d   = cnt_inc;
          ovf_win_d = ovf_win_q | add_ovf;
          if (cnt_inc == len_q) begin
            emit    = 1'b1;
            count_d = '0;
            state_d = ACC_IDLE;
          end
        end
        default: state_d = ACC_IDLE;
      endcase
    end
  end

  // Window state, element counter, running sum.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ACC_IDLE;
      count_q   <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      ovf_win_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      ovf_win_q <= ovf_win_d;
    end
  end

  // Result registers: strobe one cycle, value/flag held until next emit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_valid_q <= emit;
      if (emit) begin
        acc_q <= emit_sum;
        ovf_q <= emit_ovf;
      end
    end
  end

  assign acc_o       = acc_q;
  assign acc_valid_o = acc_valid_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q == ACC_RUN);

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: window-list model plus literal scenarios.
// Random phase follows the directed scenarios.
module tb_pe_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] data = 32'd0;
  logic        valid = 1'b0;
  logic [31:0] acc;
  logic        acc_valid;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  int win[$];
  int wlen = 1;
  int exp_acc = 0;
  bit exp_val = 1'b0;
  bit exp_ovf = 1'b0;

  int seen[$];
  bit seen_ovf[$];

  always #5 clk = ~clk;

  pe_accumulator #(.N_BITS(32), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .clear_i    (clr),
    .acc_len_i  (len),
    .data_i     (data),
    .valid_i    (valid),
    .acc_o      (acc),
    .acc_valid_o(acc_valid),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Signed sum of a completed window with per-add overflow detection.
  task automatic window_sum(output int s, output bit o);
    longint t;
    s = win[0];
    o = 1'b0;
    for (int i = 1; i < win.size(); i++) begin
      t = longint'(s) + longint'(win[i]);
      if (t > 64'sd2147483647 || t < -64'sd2147483648) o = 1'b1;
      s = int'(t);
    end
  endtask

  task automatic model_step();
    int s;
    bit o;
    exp_val = 1'b0;
    if (!rst_n) begin
      win.delete();
      exp_acc = 0;
      exp_ovf = 1'b0;
    end else if (clr) begin
      win.delete();
    end else if (en && valid) begin
      if (win.size() == 0) wlen = (len <= 8'd1) ? 1 : int'(len);
      win.push_back(int'(data));
      if (win.size() == wlen) begin
        window_sum(s, o);
        exp_acc = s;
        exp_ovf = o;
        exp_val = 1'b1;
        win.delete();
      end
    end
  endtask

  // Model update at each edge, compare 1ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    if (!done) begin
      chk("acc_valid", {31'd0, acc_valid}, {31'd0, exp_val});
      chk("acc_o", acc, exp_acc);
      chk("ovf_o", {31'd0, ovf}, {31'd0, exp_ovf});
      chk("busy_o", {31'd0, busy}, {31'd0, win.size() != 0});
      if (acc_valid) begin
        seen.push_back(int'(acc));
        seen_ovf.push_back(ovf);
      end
    end
  end

  task automatic drive(input logic [31:0] d, input bit v,
                       input bit e = 1'b1, input bit c = 1'b0);
    @(negedge clk);
    data  = d;
    valid = v;
    en    = e;
    clr   = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'd0, 1'b0);
  endtask

  task automatic start(input logic [7:0] l);
    seen.delete();
    seen_ovf.delete();
    len = l;
  endtask

  task automatic chk_seen(input string name, input int n,
                          input int v0, input int vl);
    chk({name, "_n"}, seen.size(), n);
    if (seen.size() == n && n > 0) begin
      chk({name, "_first"}, seen[0], v0);
      chk({name, "_last"}, seen[n-1], vl);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 32'd0);
    chk("rst_flags", {29'd0, acc_valid, ovf, busy}, 32'd0);
    rst_n = 1'b1;
    en = 1'b1;

    start(8'd4);
    for (int i = 1; i <= 4; i++) drive(i, 1'b1);
    idle(2);
    chk_seen("len4", 1, 10, 10);
    chk("len4_ovf", {31'd0, ovf}, 32'd0);

    start(8'd3);
    drive(32'd5, 1'b1);
    drive(32'd0, 1'b0);
    chk("gap_busy1", {31'd0, busy}, 32'd1);
    drive(-32'sd2, 1'b1);
    drive(32'd0, 1'b0);
    drive(32'd0, 1'b0);
    chk("gap_busy2", {31'd0, busy}, 32'd1);
    drive(32'd7, 1'b1);
    idle(2);
    chk_seen("gaps", 1, 10, 10);
    chk("gap_idle", {31'd0, busy}, 32'd0);

    start(8'd2);
    for (int i = 1; i <= 8; i++) drive(i, 1'b1);
    idle(2);
    chk_seen("b2b", 4, 3, 15);
    if (seen.size() == 4) begin
      chk("b2b_1", seen[1], 7);
      chk("b2b_2", seen[2], 11);
    end

    start(8'd2);
    drive(32'h7FFF_FFFF, 1'b1);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1);
    idle(2);
    chk_seen("ovf", 2, 32'h8000_0000, 2);
    if (seen_ovf.size() == 2) begin
      chk("ovf_flag", {31'd0, seen_ovf[0]}, 32'd1);
      chk("ovf_clr", {31'd0, seen_ovf[1]}, 32'd0);
    end

    start(8'd4);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1);
    drive(32'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(32'd1, 1'b1);
    idle(2);
    chk_seen("clear", 1, 4, 4);
    start(8'd4);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1);
    drive(32'd1, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk_seen("clr_last", 0, 0, 0);
    chk("clr_hold", acc, 32'd4);
    start(8'd0);
    drive(32'd9, 1'b1);
    idle(2);
    chk_seen("len0", 1, 9, 9);

    start(8'd3);
    drive(32'd1, 1'b1);
    repeat (5) drive(32'd100, 1'b1, 1'b0);
    chk("pause_busy", {31'd0, busy}, 32'd1);
    drive(32'd2, 1'b1);
    drive(32'd3, 1'b1);
    idle(2);
    chk_seen("pause", 1, 6, 6);

    start(8'd3);
    drive(32'd1, 1'b1);
    drive(32'd2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("mid_rst_acc", acc, 32'd0);
    chk("mid_rst_flags", {29'd0, acc_valid, ovf, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd4, 1'b1);
    drive(32'd5, 1'b1);
    drive(32'd6, 1'b1);
    idle(2);
    chk_seen("after_rst", 1, 15, 15);

    start(8'd255);
    for (int i = 1; i <= 255; i++) drive(i, 1'b1);
    idle(2);
    chk_seen("len255", 1, 32640, 32640);

    for (int i = 0; i < 2500; i++) begin
      int p;
      logic [31:0] d;
      p = $urandom_range(0, 99);
      if (p < 10) d = 32'h7FFF_FFF0 + $urandom_range(0, 31);
      else if (p < 20) d = 32'h8000_0000 + $urandom_range(0, 31);
      else if (p < 60) d = $urandom_range(0, 200) - 100;
      else d = $urandom;
      if ($urandom_range(0, 19) == 0) len = $urandom_range(0, 6);
      drive(d, $urandom_range(0, 9) < 7, $urandom_range(0, 9) != 0,
            $urandom_range(0, 39) == 0);
    end
    idle(3);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
